// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter in front of a single-ported synchronous word memory.
// Port A is the accumulator sequencer, port B the host loader. One port owns
// the memory at a time (registered grant). An access is issued in a cycle
// only when the owner is also requesting. Read data returns one cycle after
// the read enable and is flagged to the issuing port with rvalid.
//
// Ports:
//   clk                  clock, rising edge
//   reset                asynchronous, active-high reset
//   i_req_a / i_req_b    access request
//   i_we_a / i_we_b      1 = write, 0 = read (qualified by request)
//   i_addr_a / i_addr_b  word address
//   i_wdata_a/i_wdata_b  write data
//   i_lock_a / i_lock_b  hold grant across consecutive accesses
//   o_gnt_a / o_gnt_b    port owns the memory this cycle
//   o_rvalid_a/_b        read data valid for that port
//   o_rdata              shared read data (mirror of i_mem_data_out)
//   o_mem_address        memory address
//   o_mem_read_enable    memory read strobe
//   o_mem_write_enable   memory write strobe
//   o_mem_data_in        memory write data
//   i_mem_data_out       memory read data, valid one cycle after read enable
//   o_conflict_cnt       saturating count of cycles where a requester waited
//                        while the other port accessed the memory
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_req_a,
  input  logic              i_we_a,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [DATA_W-1:0] i_wdata_a,
  input  logic              i_lock_a,

  input  logic              i_req_b,
  input  logic              i_we_b,
  input  logic [ADDR_W-1:0] i_addr_b,
  input  logic [DATA_W-1:0] i_wdata_b,
  input  logic              i_lock_b,

  output logic              o_gnt_a,
  output logic              o_gnt_b,
  output logic              o_rvalid_a,
  output logic              o_rvalid_b,
  output logic [DATA_W-1:0] o_rdata,

  output logic [ADDR_W-1:0] o_mem_address,
  output logic              o_mem_read_enable,
  output logic              o_mem_write_enable,
  output logic [DATA_W-1:0] o_mem_data_in,
  input  logic [DATA_W-1:0] i_mem_data_out,

  output logic [7:0]        o_conflict_cnt
);

  typedef enum logic [1:0] {
    StNone = 2'd0,
    StOwnA = 2'd1,
    StOwnB = 2'd2
  } owner_e;

  // State
  owner_e      r_owner;
  logic        r_last_b;      // 1 = port B served the most recent access
  logic        r_rvalid_a;
  logic        r_rvalid_b;
  logic [7:0]  r_conflict_cnt;

  // Next-state / combinational
  owner_e      w_owner_next;
  logic        w_last_b_next;
  logic        w_rvalid_a_next;
  logic        w_rvalid_b_next;
  logic [7:0]  w_conflict_cnt_next;
  logic        w_issue_a;
  logic        w_issue_b;
  logic        w_conflict;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner        <= StNone;
      r_last_b       <= 1'b1;  // A wins the first tie after reset
      r_rvalid_a     <= 1'b0;
      r_rvalid_b     <= 1'b0;
      r_conflict_cnt <= 8'd0;
    end else begin
      r_owner        <= w_owner_next;
      r_last_b       <= w_last_b_next;
      r_rvalid_a     <= w_rvalid_a_next;
      r_rvalid_b     <= w_rvalid_b_next;
      r_conflict_cnt <= w_conflict_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and memory-side outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_owner_next        = StNone;
    w_last_b_next       = r_last_b;
    w_rvalid_a_next     = 1'b0;
    w_rvalid_b_next     = 1'b0;
    w_conflict_cnt_next = r_conflict_cnt;
    w_issue_a           = 1'b0;
    w_issue_b           = 1'b0;
    w_conflict          = 1'b0;
    o_mem_address       = '0;
    o_mem_data_in       = '0;
    o_mem_read_enable   = 1'b0;
    o_mem_write_enable  = 1'b0;

    // An owner that is not requesting this cycle issues nothing.
    w_issue_a = (r_owner == StOwnA) && i_req_a;
    w_issue_b = (r_owner == StOwnB) && i_req_b;

    if (w_issue_a) begin
      o_mem_address      = i_addr_a;
      o_mem_data_in      = i_wdata_a;
      o_mem_write_enable = i_we_a;
      o_mem_read_enable  = !i_we_a;
      w_last_b_next      = 1'b0;
      w_rvalid_a_next    = !i_we_a;
    end else if (w_issue_b) begin
      o_mem_address      = i_addr_b;
      o_mem_data_in      = i_wdata_b;
      o_mem_write_enable = i_we_b;
      o_mem_read_enable  = !i_we_b;
      w_last_b_next      = 1'b1;
      w_rvalid_b_next    = !i_we_b;
    end

    // Priority: locked owner keeps it, then hand over to a waiting other
    // port, then an unlocked owner keeps it, else release.
    unique case (r_owner)
      StOwnA: begin
        if (i_req_a && i_lock_a) begin
          w_owner_next = StOwnA;
        end else if (i_req_b) begin
          w_owner_next = StOwnB;
        end else if (i_req_a) begin
          w_owner_next = StOwnA;
        end else begin
          w_owner_next = StNone;
        end
      end
      StOwnB: begin
        if (i_req_b && i_lock_b) begin
          w_owner_next = StOwnB;
        end else if (i_req_a) begin
          w_owner_next = StOwnA;
        end else if (i_req_b) begin
          w_owner_next = StOwnB;
        end else begin
          w_owner_next = StNone;
        end
      end
      default: begin
        // From idle, a tie goes to the port not served last.
        if (i_req_a && i_req_b) begin
          w_owner_next = r_last_b ? StOwnA : StOwnB;
        end else if (i_req_a) begin
          w_owner_next = StOwnA;
        end else if (i_req_b) begin
          w_owner_next = StOwnB;
        end else begin
          w_owner_next = StNone;
        end
      end
    endcase

    // A waiting requester only counts when the other port actually accessed.
    w_conflict = (i_req_a && (r_owner != StOwnA) && w_issue_b) ||
                 (i_req_b && (r_owner != StOwnB) && w_issue_a);
    if (w_conflict && (r_conflict_cnt != 8'hFF)) begin
      w_conflict_cnt_next = r_conflict_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Port-side outputs
  // ---------------------------------------------------------------------------
  assign o_gnt_a        = (r_owner == StOwnA);
  assign o_gnt_b        = (r_owner == StOwnB);
  assign o_rvalid_a     = r_rvalid_a;
  assign o_rvalid_b     = r_rvalid_b;
  assign o_rdata        = i_mem_data_out;
  assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. A small synchronous memory model answers the
// arbiter; it is preloaded with 16'hA000 | addr while reset is high. Inputs are
// driven 1 time unit after the rising edge and outputs checked 1 unit later.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_a, we_a, lock_a;
  logic          req_b, we_b, lock_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_address;
  logic          mem_read_enable, mem_write_enable;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic [7:0]    conflict_cnt;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .i_req_a            (req_a),
    .i_we_a             (we_a),
    .i_addr_a           (addr_a),
    .i_wdata_a          (wdata_a),
    .i_lock_a           (lock_a),
    .i_req_b            (req_b),
    .i_we_b             (we_b),
    .i_addr_b           (addr_b),
    .i_wdata_b          (wdata_b),
    .i_lock_b           (lock_b),
    .o_gnt_a            (gnt_a),
    .o_gnt_b            (gnt_b),
    .o_rvalid_a         (rvalid_a),
    .o_rvalid_b         (rvalid_b),
    .o_rdata            (rdata),
    .o_mem_address      (mem_address),
    .o_mem_read_enable  (mem_read_enable),
    .o_mem_write_enable (mem_write_enable),
    .o_mem_data_in      (mem_data_in),
    .i_mem_data_out     (mem_data_out),
    .o_conflict_cnt     (conflict_cnt)
  );

  // Memory model: one-cycle read latency, preloaded while reset is high.
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'hA000 | 16'(i);
      mem_data_out <= '0;
    end else begin
      if (mem_write_enable) mem[mem_address] <= mem_data_in;
      if (mem_read_enable)  mem_data_out <= mem[mem_address];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_a = 1'b0; we_a = 1'b0; lock_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; lock_b = 1'b0; addr_b = '0; wdata_b = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;

    // Reset state
    chk("rst_gnt_a",    32'(gnt_a), 32'd0);
    chk("rst_gnt_b",    32'(gnt_b), 32'd0);
    chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
    chk("rst_rvalid_b", 32'(rvalid_b), 32'd0);
    chk("rst_cnt",      32'(conflict_cnt), 32'd0);
    chk("rst_re",       32'(mem_read_enable), 32'd0);
    chk("rst_we",       32'(mem_write_enable), 32'd0);
    reset = 1'b0;

    // Single read from A at address 4
    tick(); req_a = 1'b1; we_a = 1'b0; addr_a = 5'd4; #1;
    chk("rd_c0_gnt_a", 32'(gnt_a), 32'd0);
    chk("rd_c0_re",    32'(mem_read_enable), 32'd0);
    tick(); #1;
    chk("rd_c1_gnt_a", 32'(gnt_a), 32'd1);
    chk("rd_c1_re",    32'(mem_read_enable), 32'd1);
    chk("rd_c1_we",    32'(mem_write_enable), 32'd0);
    chk("rd_c1_addr",  32'(mem_address), 32'd4);
    tick(); req_a = 1'b0; #1;
    chk("rd_c2_rvalid", 32'(rvalid_a), 32'd1);
    chk("rd_c2_rdata",  32'(rdata), 32'hA004);
    chk("rd_c2_re_idle", 32'(mem_read_enable), 32'd0);
    chk("rd_c2_addr_idle", 32'(mem_address), 32'd0);
    tick(); #1;
    chk("rd_c3_gnt_a",  32'(gnt_a), 32'd0);
    chk("rd_c3_rvalid", 32'(rvalid_a), 32'd0);

    // Write from B to address 31
    tick(); req_b = 1'b1; we_b = 1'b1; addr_b = 5'd31; wdata_b = 16'h1234; #1;
    chk("wr_c0_gnt_b", 32'(gnt_b), 32'd0);
    tick(); #1;
    chk("wr_c1_gnt_b", 32'(gnt_b), 32'd1);
    chk("wr_c1_we",    32'(mem_write_enable), 32'd1);
    chk("wr_c1_re",    32'(mem_read_enable), 32'd0);
    chk("wr_c1_addr",  32'(mem_address), 32'd31);
    chk("wr_c1_din",   32'(mem_data_in), 32'h1234);
    tick(); req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0; #1;
    chk("wr_c2_rvalid_b", 32'(rvalid_b), 32'd0);
    chk("wr_c2_we",       32'(mem_write_enable), 32'd0);
    tick(); #1;
    chk("wr_c3_rvalid_b", 32'(rvalid_b), 32'd0);
    chk("wr_c3_gnt_b",    32'(gnt_b), 32'd0);

    // Read back address 31 through A
    tick(); req_a = 1'b1; addr_a = 5'd31; #1;
    tick(); #1;
    chk("rb_c1_addr", 32'(mem_address), 32'd31);
    tick(); req_a = 1'b0; addr_a = '0; #1;
    chk("rb_c2_rvalid", 32'(rvalid_a), 32'd1);
    chk("rb_c2_rdata",  32'(rdata), 32'h1234);
    chk("rb_cnt_zero",  32'(conflict_cnt), 32'd0);
    tick(); #1;

    // Tie after reset: A first, then alternate
    reset = 1'b1; #1; reset = 1'b0;
    req_a = 1'b1; addr_a = 5'd1; req_b = 1'b1; addr_b = 5'd2; #1;
    chk("tie_t0_gnt_a", 32'(gnt_a), 32'd0);
    chk("tie_t0_gnt_b", 32'(gnt_b), 32'd0);
    chk("tie_t0_cnt",   32'(conflict_cnt), 32'd0);
    tick(); #1;
    chk("tie_t1_gnt_a", 32'(gnt_a), 32'd1);
    chk("tie_t1_gnt_b", 32'(gnt_b), 32'd0);
    chk("tie_t1_addr",  32'(mem_address), 32'd1);
    chk("tie_t1_cnt",   32'(conflict_cnt), 32'd0);
    tick(); #1;
    chk("tie_t2_gnt_b",    32'(gnt_b), 32'd1);
    chk("tie_t2_gnt_a",    32'(gnt_a), 32'd0);
    chk("tie_t2_addr",     32'(mem_address), 32'd2);
    chk("tie_t2_cnt",      32'(conflict_cnt), 32'd1);
    chk("tie_t2_rvalid_a", 32'(rvalid_a), 32'd1);
    chk("tie_t2_rdata",    32'(rdata), 32'hA001);
    tick(); #1;
    chk("tie_t3_gnt_a",    32'(gnt_a), 32'd1);
    chk("tie_t3_cnt",      32'(conflict_cnt), 32'd2);
    chk("tie_t3_rvalid_b", 32'(rvalid_b), 32'd1);
    chk("tie_t3_rvalid_a", 32'(rvalid_a), 32'd0);
    chk("tie_t3_rdata",    32'(rdata), 32'hA002);
    tick(); #1;
    chk("tie_t4_gnt_b", 32'(gnt_b), 32'd1);
    chk("tie_t4_cnt",   32'(conflict_cnt), 32'd3);
    tick(); req_a = 1'b0; req_b = 1'b0; #1;
    chk("tie_t5_gnt_a", 32'(gnt_a), 32'd1);
    chk("tie_t5_re",    32'(mem_read_enable), 32'd0);
    chk("tie_t5_cnt",   32'(conflict_cnt), 32'd4);

    // Lock burst: A holds over addresses 0..3 while B waits
    tick(); req_a = 1'b1; lock_a = 1'b1; addr_a = 5'd0; req_b = 1'b1; addr_b = 5'd7; #1;
    chk("lk_l0_gnt_a", 32'(gnt_a), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(); addr_a = 5'(k);
      if (k == 3) lock_a = 1'b0;
      #1;
      chk("lk_gnt_a", 32'(gnt_a), 32'd1);
      chk("lk_gnt_b", 32'(gnt_b), 32'd0);
      chk("lk_addr",  32'(mem_address), 32'(k));
    end
    tick(); req_a = 1'b0; #1;
    chk("lk_l5_gnt_b",    32'(gnt_b), 32'd1);
    chk("lk_l5_addr",     32'(mem_address), 32'd7);
    chk("lk_l5_rvalid_a", 32'(rvalid_a), 32'd1);
    chk("lk_l5_rdata",    32'(rdata), 32'hA003);
    chk("lk_l5_cnt",      32'(conflict_cnt), 32'd8);
    tick(); req_b = 1'b0; addr_b = '0; #1;
    chk("lk_l6_rvalid_b", 32'(rvalid_b), 32'd1);
    chk("lk_l6_rdata",    32'(rdata), 32'hA007);

    // Reset during the cycle after a granted read
    tick(); req_a = 1'b1; addr_a = 5'd5; #1;
    tick(); #1;
    chk("rr_c1_gnt_a", 32'(gnt_a), 32'd1);
    chk("rr_c1_re",    32'(mem_read_enable), 32'd1);
    tick(); req_a = 1'b0; addr_a = '0; #1;
    chk("rr_c2_rvalid_pre", 32'(rvalid_a), 32'd1);
    reset = 1'b1; #1;
    chk("rr_rst_rvalid", 32'(rvalid_a), 32'd0);
    chk("rr_rst_gnt_a",  32'(gnt_a), 32'd0);
    chk("rr_rst_cnt",    32'(conflict_cnt), 32'd0);
    chk("rr_rst_re",     32'(mem_read_enable), 32'd0);
    tick(); #1;
    chk("rr_hold_rvalid", 32'(rvalid_a), 32'd0);
    reset = 1'b0;
    tick(); #1;
    chk("rr_rel_rvalid", 32'(rvalid_a), 32'd0);
    chk("rr_rel_gnt_a",  32'(gnt_a), 32'd0);

    // 300 contention cycles: alternate A,B,... and saturate at 255
    tick(); req_a = 1'b1; req_b = 1'b1; addr_a = 5'd9; addr_b = 5'd10; #1;
    chk("sat_c0_cnt", 32'(conflict_cnt), 32'd0);
    for (int k = 1; k <= 300; k++) begin
      tick(); #1;
      chk("sat_alt_a", 32'(gnt_a), 32'(k % 2));
      chk("sat_excl",  32'(gnt_a & gnt_b), 32'd0);
      chk("sat_one_en", 32'(mem_read_enable & mem_write_enable), 32'd0);
      if (k == 10)  chk("sat_c10_cnt",  32'(conflict_cnt), 32'd9);
      if (k == 255) chk("sat_c255_cnt", 32'(conflict_cnt), 32'd254);
      if (k == 256) chk("sat_c256_cnt", 32'(conflict_cnt), 32'd255);
    end
    chk("sat_c300_cnt", 32'(conflict_cnt), 32'd255);
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
